// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush sequencer: D-cache miss FSM, load-use hazard, branch flush, watchdog.
// Optional performance counters are enabled with `define PIPE_CTRL_PERF_EN.
module pipeline_ctrl #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_uses_rs2_i,
  input  logic       ex_memread_i,
  input  logic [4:0] ex_rd_i,
  input  logic       id_branch_taken_i,
  input  logic       dmem_req_i,
  input  logic       dmem_ack_i,
  output logic       pc_write_o,
  output logic       if_id_stall_o,
  output logic       if_id_flush_o,
  output logic       id_ex_bubble_o,
  output logic       mem_stall_o,
  output logic       timeout_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] miss_cnt_o
`endif
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout_q, timeout_d;
  logic          load_use;
  logic          miss;
  logic          mem_stall;

  assign load_use = ex_memread_i && (ex_rd_i != 5'd0) &&
                    ((ex_rd_i == id_rs1_i) || (id_uses_rs2_i && (ex_rd_i == id_rs2_i)));
  assign miss     = dmem_req_i && !dmem_ack_i;

  // Next state, memory stall and watchdog
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    mem_stall  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) state_d = S_RUN;
      end
      S_RUN: begin
        if (miss) begin
          state_d    = S_MEM_WAIT;
          wait_cnt_d = '0;
          mem_stall  = 1'b1;
        end else if (!start_i) begin
          state_d = S_IDLE;
        end
      end
      S_MEM_WAIT: begin
        if (dmem_ack_i) begin
          state_d = S_RUN;
        end else begin
          mem_stall = 1'b1;
          if (wait_cnt_q != CW'(TIMEOUT)) wait_cnt_d = wait_cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Watchdog trips on the edge that makes the count reach TIMEOUT
    if ((TIMEOUT != 0) && (state_q == S_MEM_WAIT) && !dmem_ack_i &&
        (wait_cnt_d == CW'(TIMEOUT))) begin
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  // Prioritised control outputs
  always_comb begin
    pc_write_o     = 1'b1;
    if_id_stall_o  = 1'b0;
    if_id_flush_o  = 1'b0;
    id_ex_bubble_o = 1'b0;
    if (state_q == S_IDLE) begin
      pc_write_o    = 1'b0;
      if_id_stall_o = 1'b1;
    end else if (mem_stall) begin
      pc_write_o = 1'b0;
    end else if (load_use) begin
      pc_write_o     = 1'b0;
      if_id_stall_o  = 1'b1;
      id_ex_bubble_o = 1'b1;
    end else if (id_branch_taken_i) begin
      if_id_flush_o = 1'b1;
    end
  end

  assign mem_stall_o = mem_stall;
  assign timeout_o   = timeout_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;
  logic        stall_inc, flush_inc, miss_inc;

  assign stall_inc = (state_q != S_IDLE) && (mem_stall || load_use);
  assign flush_inc = if_id_flush_o;
  assign miss_inc  = (state_q == S_RUN) && miss;

  // Saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_inc && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
    if (miss_inc && (miss_cnt_q != 32'hFFFF_FFFF))   miss_cnt_d  = miss_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      miss_cnt_q  <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign miss_cnt_o  = miss_cnt_q;
`endif

endmodule
